// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART: state encodings, bit timing helpers
// and default clock/baud settings.
package uart_pkg;

  localparam int unsigned DEF_CLK_FREQ = 100_000_000;
  localparam int unsigned DEF_BAUD     = 115_200;
  localparam int unsigned DATA_W       = 8;
  localparam int unsigned BIT_IDX_W    = 3;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  // Clocks per serial bit (integer division).
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

  // Clocks from a bit edge to its mid-point.
  function automatic int unsigned half_bit(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clks_per_bit(clk_freq, baud) / 2;
  endfunction

  // Width of a counter that must hold 0 .. cpb-1.
  function automatic int unsigned cnt_width(input int unsigned cpb);
    return (cpb > 1) ? $clog2(cpb) : 1;
  endfunction

endpackage

// File: rtl/uart_if.sv
// UART signal bundle. master = the side driving start/txin/rx (system or
// bench), slave = the UART block itself.
interface uart_if;
  import uart_pkg::*;

  logic              start;
  logic [DATA_W-1:0] txin;
  logic              tx;
  logic              rx;
  logic [DATA_W-1:0] rxout;
  logic              rxdone;
  logic              txdone;

  modport master (
    output start, txin, rx,
    input  tx, rxout, rxdone, txdone
  );

  modport slave (
    input  start, txin, rx,
    output tx, rxout, rxdone, txdone
  );

endinterface

// File: rtl/uart_rx.sv
// 8N1 receiver with 2-flop input synchronizer and mid-bit sampling.
//   clk, rst_n : clock, async active-low reset
//   rx_i       : serial line, idle high
//   rxout_o    : last correctly framed byte
//   rxdone_o   : one-cycle pulse when rxout_o is updated
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
  parameter int unsigned BAUD     = DEF_BAUD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_i,
  output logic [DATA_W-1:0] rxout_o,
  output logic              rxdone_o
);

  localparam int unsigned CPB       = clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned HALF      = half_bit(CLK_FREQ, BAUD);
  localparam int unsigned CNT_W     = cnt_width(CPB);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

  rx_state_e              state_q;
  logic                   rx_meta_q;
  logic                   rx_sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [BIT_IDX_W-1:0]   bit_q;
  logic [DATA_W-1:0]      shreg_q;
  logic                   stop_ok_q;
  logic [DATA_W-1:0]      rxout_q;
  logic                   rxdone_q;

  // Synchronizer plus frame sequencer. stop_ok_q marks the second half of a
  // good stop bit, which is waited out before the byte is published.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      stop_ok_q <= 1'b0;
      rxout_q   <= '0;
      rxdone_q  <= 1'b0;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rxdone_q  <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          cnt_q     <= '0;
          stop_ok_q <= 1'b0;
          if (!rx_sync_q) state_q <= RX_START;
        end
        RX_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            // A line already back high at mid start bit was a glitch.
            state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            shreg_q <= {rx_sync_q, shreg_q[DATA_W-1:1]};
            bit_q   <= bit_q + BIT_IDX_W'(1);
            if (bit_q == BIT_IDX_W'(DATA_W - 1)) state_q <= RX_STOP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (!stop_ok_q) begin
            if (cnt_q == CNT_LAST) begin
              cnt_q <= '0;
              if (rx_sync_q) stop_ok_q <= 1'b1;
              else           state_q   <= RX_WAIT_HIGH;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end else if (cnt_q == HALF_LAST) begin
            cnt_q     <= '0;
            stop_ok_q <= 1'b0;
            rxout_q   <= shreg_q;
            rxdone_q  <= 1'b1;
            state_q   <= RX_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RX_WAIT_HIGH: begin
          if (rx_sync_q) state_q <= RX_IDLE;
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign rxout_o  = rxout_q;
  assign rxdone_o = rxdone_q;

endmodule

// File: rtl/uart_tx.sv
// 8N1 transmitter.
//   clk, rst_n : clock, async active-low reset
//   start_i    : level enable; frames go out back-to-back while high
//   txin_i     : byte latched when a frame is launched
//   tx_o       : serial line, idle high
//   txdone_o   : one-cycle pulse after the stop bit completes
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
  parameter int unsigned BAUD     = DEF_BAUD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [DATA_W-1:0] txin_i,
  output logic              tx_o,
  output logic              txdone_o
);

  localparam int unsigned CPB      = clks_per_bit(CLK_FREQ, BAUD);
  localparam int unsigned CNT_W    = cnt_width(CPB);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);

  tx_state_e              state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [BIT_IDX_W-1:0]   bit_q;
  logic [DATA_W-1:0]      shreg_q;
  logic                   tx_q;
  logic                   txdone_q;

  // Frame sequencer; tx_q is the registered line value for the current state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= TX_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      tx_q     <= 1'b1;
      txdone_q <= 1'b0;
    end else begin
      txdone_q <= 1'b0;
      case (state_q)
        TX_IDLE: begin
          tx_q  <= 1'b1;
          cnt_q <= '0;
          if (start_i) begin
            shreg_q <= txin_i;
            tx_q    <= 1'b0;
            state_q <= TX_START;
          end
        end
        TX_START: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= shreg_q[0];
            state_q <= TX_DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        TX_DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (bit_q == BIT_IDX_W'(DATA_W - 1)) begin
              tx_q    <= 1'b1;
              state_q <= TX_STOP;
            end else begin
              // Present the next bit while shifting it down to bit 0.
              shreg_q <= {1'b0, shreg_q[DATA_W-1:1]};
              tx_q    <= shreg_q[1];
              bit_q   <= bit_q + BIT_IDX_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        TX_STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q    <= '0;
            txdone_q <= 1'b1;
            state_q  <= TX_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

  assign tx_o     = tx_q;
  assign txdone_o = txdone_q;

endmodule

// File: rtl/uart_top.sv
// 8N1 UART: independent transmitter and receiver on a shared clock/reset.
//   clk, rst_n : clock, async active-low reset
//   bus        : uart_if.slave (start, txin, tx, rx, rxout, rxdone, txdone)
module uart_top
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
  parameter int unsigned BAUD     = DEF_BAUD
) (
  input  logic  clk,
  input  logic  rst_n,
  uart_if.slave bus
);

  uart_tx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (bus.start),
    .txin_i   (bus.txin),
    .tx_o     (bus.tx),
    .txdone_o (bus.txdone)
  );

  uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_i     (bus.rx),
    .rxout_o  (bus.rxout),
    .rxdone_o (bus.rxdone)
  );

endmodule

// File: tb/tb_uart_top.sv
// Bench for uart_top: expected bytes are queued when frames are issued and a
// monitor pops/compares them on every rxdone.
module tb_uart_top;
  import uart_pkg::*;

  localparam int unsigned CLK_FREQ = 2_000_000;
  localparam int unsigned BAUD     = 100_000;
  localparam int unsigned CPB      = CLK_FREQ / BAUD;
  localparam int unsigned FRAME    = 10 * CPB;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic loop   = 1'b0;
  logic rx_drv = 1'b1;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  logic [7:0] last_good = 8'h00;
  int         txdone_cnt = 0;
  logic       tx_pending = 1'b0;

  uart_if bus();
  assign bus.rx = loop ? bus.tx : rx_drv;

  uart_top #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Line level of bit k of an 8N1 frame carrying d.
  function automatic logic frame_bit(input logic [7:0] d, input int k);
    logic [9:0] f;
    f = {1'b1, d, 1'b0};
    return f[k];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_txdone(input int budget, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!bus.txdone && cycles < budget);
    chk1("txdone_seen", bus.txdone, 1'b1);
  endtask

  task automatic wait_rxdone(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rxdone && n < budget);
    chk1("rxdone_seen", bus.rxdone, 1'b1);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    chk_int("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = f[i];
      tick(CPB);
    end
    rx_drv = 1'b1;
  endtask

  // Monitor: scoreboard pops on rxdone, loopback ordering of txdone/rxdone.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.txdone) begin
        txdone_cnt++;
        if (loop) begin
          chk1("txdone_before_prev_rxdone", tx_pending, 1'b0);
          tx_pending = 1'b1;
        end
      end
      if (bus.rxdone) begin
        if (loop) begin
          chk1("rxdone_after_txdone", tx_pending, 1'b1);
          tx_pending = 1'b0;
        end
        chk1("rxdone_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          logic [7:0] e;
          e = exp_q.pop_front();
          chk8("rxout", bus.rxout, e);
          last_good = e;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int         cyc;
    int         n0;
    logic [7:0] b;

    bus.start = 1'b0;
    bus.txin  = 8'h00;

    // Reset, then quiet lines.
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      chk1("idle_tx", bus.tx, 1'b1);
      chk1("idle_txdone", bus.txdone, 1'b0);
      chk1("idle_rxdone", bus.rxdone, 1'b0);
      chk8("idle_rxout", bus.rxout, 8'h00);
      tick(1);
    end

    // rx held low straight out of reset: no rxdone, rxout stays 0.
    rx_drv = 1'b0;
    rst_n  = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(400);
    chk8("rxout_after_stuck_low", bus.rxout, 8'h00);
    rx_drv = 1'b1;
    tick(2 * CPB);

    // Loopback 0xA5 with start held: check the waveform bit by bit.
    loop      = 1'b1;
    bus.txin  = 8'hA5;
    bus.start = 1'b1;
    exp_q.push_back(8'hA5);
    tick(1);
    for (int k = 0; k < int'(FRAME); k++) begin
      chk1($sformatf("a5_tx_bit%0d", k / CPB), bus.tx, frame_bit(8'hA5, k / CPB));
      chk1("a5_txdone_early", bus.txdone, 1'b0);
      tick(1);
    end
    chk1("a5_txdone_pulse", bus.txdone, 1'b1);
    chk1("a5_tx_gap_high", bus.tx, 1'b1);
    // start still high: second frame follows after one idle cycle.
    exp_q.push_back(8'hA5);
    tick(1);
    chk1("a5_back_to_back_start", bus.tx, 1'b0);
    chk1("a5_txdone_single", bus.txdone, 1'b0);
    // Mid-frame changes to txin/start must not disturb this frame.
    bus.txin = 8'h00;
    tick(2 * CPB);
    bus.start = 1'b0;
    wait_txdone(FRAME + CPB, cyc);
    wait_drain(4 * CPB);
    chk8("a5_rxout", bus.rxout, 8'hA5);

    // Random loopback bytes, one frame at a time.
    for (int i = 0; i < 10; i++) begin
      b         = 8'($urandom_range(200, 10));
      bus.txin  = b;
      bus.start = 1'b1;
      exp_q.push_back(b);
      wait_txdone(FRAME + CPB, cyc);
      bus.start = 1'b0;
      chk_int("txdone_latency", cyc, FRAME + 1);
      wait_rxdone(2 * CPB);
    end
    wait_drain(4 * CPB);

    // Direct rx stimulus.
    loop   = 1'b0;
    rx_drv = 1'b1;
    tick(2 * CPB);
    rx_drv = 1'b0;
    tick(3);
    rx_drv = 1'b1;
    tick(2 * CPB);
    chk8("rxout_after_glitch", bus.rxout, last_good);

    rx_drv = 1'b0;
    tick(300);
    rx_drv = 1'b1;
    tick(2 * CPB);
    chk8("rxout_after_long_low", bus.rxout, last_good);

    send_rx(8'h3C, 1'b0);
    tick(2 * CPB);
    chk8("rxout_after_framing_error", bus.rxout, last_good);

    exp_q.push_back(8'h3C);
    send_rx(8'h3C, 1'b1);
    wait_drain(4 * CPB);
    chk8("rxout_valid_3c", bus.rxout, 8'h3C);
    tick(2 * CPB);

    // Reset during DATA of a TX frame.
    loop      = 1'b1;
    bus.txin  = 8'h5A;
    bus.start = 1'b1;
    tick(3 * CPB);
    #2 rst_n = 1'b0;
    #1;
    chk1("tx_high_in_reset", bus.tx, 1'b1);
    chk1("txdone_low_in_reset", bus.txdone, 1'b0);
    tick(2);
    bus.txin = 8'hC3;
    n0       = txdone_cnt;
    exp_q.push_back(8'hC3);
    rst_n = 1'b1;
    wait_txdone(FRAME + CPB, cyc);
    bus.start = 1'b0;
    chk_int("fresh_frame_latency", cyc, FRAME + 1);
    wait_drain(4 * CPB);
    tick(CPB);
    chk_int("txdone_count_after_reset", txdone_cnt - n0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
